// File: rtl/crc16_pkg.sv
// Shared definitions for the CRC-16 UART link framer.
//   CRC_POLY_DEF / CRC_INIT_DEF : CRC-16/CCITT-FALSE generator and seed.
//   CRC_CHECK_123456789         : CRC of ASCII "123456789" with the defaults.
//   state_e                     : framer FSM encoding (3 bits).
//   phase_e                     : which byte of the frame the WAIT state is retiring.
package crc16_pkg;

  localparam logic [15:0] CRC_POLY_DEF        = 16'h1021;
  localparam logic [15:0] CRC_INIT_DEF        = 16'hFFFF;
  localparam logic [15:0] CRC_CHECK_123456789 = 16'h29B1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSend  = 3'd1,
    StGuard = 3'd2,
    StWait  = 3'd3,
    StCrcHi = 3'd4,
    StCrcLo = 3'd5,
    StDone  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PhData = 2'd0,
    PhHi   = 2'd1,
    PhLo   = 2'd2
  } phase_e;

endpackage

// File: rtl/crc16_byte_update.sv
// Combinational CRC-16 byte update, MSB first, no reflection.
// Ports:
//   crc_in   : running CRC before this byte.
//   data     : byte to fold in.
//   crc_next : running CRC after this byte.
module crc16_byte_update
  import crc16_pkg::*;
#(
  parameter logic [15:0] CRC_POLY = CRC_POLY_DEF
) (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  always_comb begin
    // Folding the whole byte into the top first is equivalent to the bit-serial form.
    crc_next = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (crc_next[15]) begin
        crc_next = {crc_next[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_next = {crc_next[14:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/crc16_frame_tx.sv
// Transmit-side framer for the CRC-16 UART link. Forwards payload bytes to the
// UART transmitter one at a time and closes each frame with the CRC-16, high
// byte first.
// Ports:
//   clk, reset            : rising-edge clock, async active-low reset.
//   in_data/in_valid/
//   in_last/in_ready      : payload stream; transfer = in_valid & in_ready.
//   tx_data_out           : byte for the UART, stable from start pulse to end of busy.
//   tx_start_out          : one-cycle start pulse to the UART.
//   tx_busy_in            : UART busy.
//   frame_done            : one-cycle pulse after the CRC low byte has gone out.
//   crc_out               : CRC of the last completed frame.
//   overflow_err          : sticky, a frame reached MAX_LEN without in_last.
module crc16_frame_tx
  import crc16_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 16,
  parameter logic [15:0] CRC_POLY = CRC_POLY_DEF,
  parameter logic [15:0] CRC_INIT = CRC_INIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  tx_data_out,
  output logic        tx_start_out,
  input  logic        tx_busy_in,
  output logic        frame_done,
  output logic [15:0] crc_out,
  output logic        overflow_err
);

  localparam logic [8:0] MaxLenW = 9'(MAX_LEN);

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_out_q, crc_out_d;
  logic [7:0]  count_q, count_d;
  logic        last_q, last_d;
  logic        ovf_q, ovf_d;

  logic [15:0] crc_upd;
  logic [8:0]  count_inc;
  logic        hit_max;
  logic        transfer;

  crc16_byte_update #(
    .CRC_POLY (CRC_POLY)
  ) u_crc (
    .crc_in   (crc_q),
    .data     (in_data),
    .crc_next (crc_upd)
  );

  assign count_inc = {1'b0, count_q} + 9'd1;
  assign hit_max   = (count_inc == MaxLenW);

  // Gated by reset so in_ready reads 0 while reset is held.
  assign in_ready = reset && (state_q == StIdle) && !tx_busy_in;
  assign transfer = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    tx_data_d    = tx_data_q;
    crc_d        = crc_q;
    crc_out_d    = crc_out_q;
    count_d      = count_q;
    last_d       = last_q;
    ovf_d        = ovf_q;
    tx_start_out = 1'b0;
    frame_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          tx_data_d = in_data;
          crc_d     = crc_upd;
          count_d   = count_inc[7:0];
          last_d    = in_last || hit_max;
          phase_d   = PhData;
          if (hit_max && !in_last) begin
            ovf_d = 1'b1;
          end
          state_d = StSend;
        end
      end
      StSend: begin
        tx_start_out = 1'b1;
        state_d      = StGuard;
      end
      // The transmitter raises busy one cycle after the start pulse; skip that cycle.
      StGuard: begin
        state_d = StWait;
      end
      StWait: begin
        if (!tx_busy_in) begin
          unique case (phase_q)
            PhData: state_d = last_q ? StCrcHi : StIdle;
            PhHi:   state_d = StCrcLo;
            PhLo: begin
              // Capture here so crc_out is already valid during the frame_done pulse.
              state_d   = StDone;
              crc_out_d = crc_q;
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StCrcHi: begin
        tx_data_d = crc_q[15:8];
        phase_d   = PhHi;
        state_d   = StSend;
      end
      StCrcLo: begin
        tx_data_d = crc_q[7:0];
        phase_d   = PhLo;
        state_d   = StSend;
      end
      StDone: begin
        frame_done = 1'b1;
        crc_d      = CRC_INIT;
        count_d    = 8'd0;
        last_d     = 1'b0;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      phase_q   <= PhData;
      tx_data_q <= 8'h00;
      crc_q     <= CRC_INIT;
      crc_out_q <= 16'h0000;
      count_q   <= 8'd0;
      last_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      tx_data_q <= tx_data_d;
      crc_q     <= crc_d;
      crc_out_q <= crc_out_d;
      count_q   <= count_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx_data_out  = tx_data_q;
  assign crc_out      = crc_out_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_crc16_frame_tx.sv
// Directed bench for crc16_frame_tx. Instance 0 uses MAX_LEN=16, instance 1
// uses MAX_LEN=4 for the overflow case. A simple UART model raises busy for
// busy_len cycles starting the cycle after each start pulse.
module tb_crc16_frame_tx;
  import crc16_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_valid     [2];
  logic        in_ready     [2];
  logic [7:0]  tx_data      [2];
  logic        tx_start     [2];
  logic        tx_busy      [2];
  logic        frame_done   [2];
  logic [15:0] crc_out      [2];
  logic        overflow_err [2];

  crc16_frame_tx #(.MAX_LEN(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid[0]),
    .in_last      (in_last),
    .in_ready     (in_ready[0]),
    .tx_data_out  (tx_data[0]),
    .tx_start_out (tx_start[0]),
    .tx_busy_in   (tx_busy[0]),
    .frame_done   (frame_done[0]),
    .crc_out      (crc_out[0]),
    .overflow_err (overflow_err[0])
  );

  crc16_frame_tx #(.MAX_LEN(4)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid[1]),
    .in_last      (in_last),
    .in_ready     (in_ready[1]),
    .tx_data_out  (tx_data[1]),
    .tx_start_out (tx_start[1]),
    .tx_busy_in   (tx_busy[1]),
    .frame_done   (frame_done[1]),
    .crc_out      (crc_out[1]),
    .overflow_err (overflow_err[1])
  );

  // UART model
  int busy_len = 20;
  int busy_cnt [2] = '{0, 0};
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_start[i]) busy_cnt[i] <= busy_len;
      else if (busy_cnt[i] != 0) busy_cnt[i] <= busy_cnt[i] - 1;
    end
  end
  assign tx_busy[0] = (busy_cnt[0] != 0);
  assign tx_busy[1] = (busy_cnt[1] != 0);

  // Monitor, sampled on the falling edge
  logic [7:0] cap [2][128];
  int cap_n         [2] = '{0, 0};
  int done_n        [2] = '{0, 0};
  int viol          [2] = '{0, 0};
  int last_busy_cyc [2] = '{0, 0};
  int done_gap      [2] = '{0, 0};
  int cyc = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (tx_start[i]) begin
        if (cap_n[i] < 128) cap[i][cap_n[i]] <= tx_data[i];
        cap_n[i] <= cap_n[i] + 1;
      end
      if ((tx_start[i] && tx_busy[i]) ||
          (in_ready[i] && (tx_start[i] || tx_busy[i] || frame_done[i]))) begin
        viol[i] <= viol[i] + 1;
      end
      if (tx_busy[i]) last_busy_cyc[i] <= cyc;
      if (frame_done[i]) begin
        done_n[i]   <= done_n[i] + 1;
        done_gap[i] <= cyc - last_busy_cyc[i];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-serial reference: feedback = crc[15] ^ data bit.
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  task automatic send_byte(input int s, input logic [7:0] d, input logic l, input bit toggle);
    int t;
    bit sent;
    t    = 0;
    sent = 1'b0;
    @(negedge clk);
    in_data     = d;
    in_last     = l;
    in_valid[s] = 1'b1;
    while (!sent && t < 20000) begin
      if (in_valid[s] && in_ready[s]) begin
        @(negedge clk);
        sent = 1'b1;
      end else begin
        @(negedge clk);
        t++;
        if (toggle) in_valid[s] = ~in_valid[s];
      end
    end
    in_valid[s] = 1'b0;
    in_last     = 1'b0;
    if (!sent) check_eq("send_timeout", 32'(t), 32'd0);
  endtask

  task automatic send_digits(input int s, input int n, input bit with_last, input bit toggle);
    for (int k = 0; k < n; k++) begin
      send_byte(s, 8'h31 + 8'(k), with_last && (k == n - 1), toggle);
    end
  endtask

  task automatic wait_done(input int s, input int target);
    int t;
    t = 0;
    while (done_n[s] < target && t < 20000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    if (done_n[s] < target) check_eq("done_timeout", 32'(done_n[s]), 32'(target));
  endtask

  logic [7:0] exp_b [16];

  task automatic check_stream(input string tag, input int s, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      check_eq($sformatf("%s_byte%0d", tag, k), 32'(cap[s][base + k]), 32'(exp_b[k]));
    end
  endtask

  task automatic load_digits(input logic [15:0] crc);
    for (int k = 0; k < 9; k++) exp_b[k] = 8'h31 + 8'(k);
    exp_b[9]  = crc[15:8];
    exp_b[10] = crc[7:0];
  endtask

  int b, d;
  logic [15:0] m;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    in_data     = 8'h00;
    in_last     = 1'b0;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_in_ready", 32'(in_ready[0]), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data[0]), 32'd0);
    check_eq("rst_tx_start", 32'(tx_start[0]), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done[0]), 32'd0);
    check_eq("rst_crc_out", 32'(crc_out[0]), 32'd0);
    check_eq("rst_overflow", 32'(overflow_err[0]), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle_in_ready", 32'(in_ready[0]), 32'd1);

    // 1: check string
    b = cap_n[0]; d = done_n[0];
    send_digits(0, 9, 1'b1, 1'b0);
    wait_done(0, d + 1);
    load_digits(16'h29B1);
    check_stream("t1", 0, b, 11);
    check_eq("t1_count", 32'(cap_n[0] - b), 32'd11);
    check_eq("t1_done", 32'(done_n[0] - d), 32'd1);
    check_eq("t1_crc_out", 32'(crc_out[0]), 32'h29B1);
    check_eq("t1_overflow", 32'(overflow_err[0]), 32'd0);

    // 2: gappy input, slow UART
    busy_len = 200;
    b = cap_n[0]; d = done_n[0];
    send_digits(0, 9, 1'b1, 1'b1);
    wait_done(0, d + 1);
    check_stream("t2", 0, b, 11);
    check_eq("t2_count", 32'(cap_n[0] - b), 32'd11);
    check_eq("t2_crc_out", 32'(crc_out[0]), 32'h29B1);
    busy_len = 20;

    // 3: back-to-back frames, CRC must reseed
    b = cap_n[0]; d = done_n[0];
    send_digits(0, 9, 1'b1, 1'b0);
    send_digits(0, 9, 1'b1, 1'b0);
    wait_done(0, d + 2);
    check_stream("t3a", 0, b, 11);
    check_stream("t3b", 0, b + 11, 11);
    check_eq("t3_done", 32'(done_n[0] - d), 32'd2);
    check_eq("t3_crc_out", 32'(crc_out[0]), 32'h29B1);

    // 4: MAX_LEN=4 overflow
    b = cap_n[1]; d = done_n[1];
    send_digits(1, 6, 1'b0, 1'b0);
    repeat (60) @(negedge clk);
    m = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      m = crc_model(m, 8'h31 + 8'(k));
      exp_b[k] = 8'h31 + 8'(k);
    end
    exp_b[4] = m[15:8];
    exp_b[5] = m[7:0];
    exp_b[6] = 8'h35;
    exp_b[7] = 8'h36;
    check_stream("t4", 1, b, 8);
    check_eq("t4_count", 32'(cap_n[1] - b), 32'd8);
    check_eq("t4_done", 32'(done_n[1] - d), 32'd1);
    check_eq("t4_crc_out", 32'(crc_out[1]), 32'(m));
    check_eq("t4_overflow", 32'(overflow_err[1]), 32'd1);
    repeat (10) @(negedge clk);
    check_eq("t4_overflow_sticky", 32'(overflow_err[1]), 32'd1);

    // 5: reset mid-frame after 5th start pulse
    b = cap_n[0]; d = done_n[0];
    send_digits(0, 5, 1'b0, 1'b0);
    check_eq("t5_pulse5", 32'(tx_start[0]), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("t5_tx_start", 32'(tx_start[0]), 32'd0);
    check_eq("t5_tx_data", 32'(tx_data[0]), 32'd0);
    check_eq("t5_in_ready", 32'(in_ready[0]), 32'd0);
    check_eq("t5_crc_out", 32'(crc_out[0]), 32'd0);
    check_eq("t5_overflow4", 32'(overflow_err[1]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("t5_no_crc_bytes", 32'(cap_n[0] - b), 32'd5);
    check_eq("t5_no_done", 32'(done_n[0] - d), 32'd0);
    send_digits(0, 9, 1'b1, 1'b0);
    wait_done(0, d + 1);
    load_digits(16'h29B1);
    check_stream("t5", 0, b + 5, 11);
    check_eq("t5_crc_after", 32'(crc_out[0]), 32'h29B1);

    // 6: single-byte frame, CRC(AA) = F550
    b = cap_n[0]; d = done_n[0];
    send_byte(0, 8'hAA, 1'b1, 1'b0);
    wait_done(0, d + 1);
    exp_b[0] = 8'hAA; exp_b[1] = 8'hF5; exp_b[2] = 8'h50;
    check_stream("t6", 0, b, 3);
    check_eq("t6_count", 32'(cap_n[0] - b), 32'd3);
    check_eq("t6_crc_out", 32'(crc_out[0]), 32'hF550);
    check_eq("t6_done_gap", 32'(done_gap[0]), 32'd2);

    // Protocol: no start while busy, in_ready only in IDLE
    check_eq("proto_dut", 32'(viol[0]), 32'd0);
    check_eq("proto_dut4", 32'(viol[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc16_frame_tx.md
Name: crc16_frame_tx

Overview:
Transmit-side framer that sits directly upstream of the UART transmitter in the CRC-16 UART link. It accepts payload bytes over a valid/ready stream and forwards each byte to the UART TX byte interface (tx_data/tx_start, paced by tx_busy). On the last payload byte it appends the running CRC-16 as two trailing bytes, high byte first, so the receive-side CRC check sees a valid frame.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame before a forced frame close (range 1..255).
CRC_POLY, 16'h1021, CRC-16 generator polynomial.
CRC_INIT, 16'hFFFF, CRC seed loaded at the start of every frame.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
in_data  input  8  payload byte.
in_valid  input  1  in_data is valid.
in_last  input  1  the current byte is the final payload byte of the frame.
in_ready  output  1  the block accepts in_data this cycle (transfer = in_valid & in_ready).
tx_data_out  output  8  byte to the UART transmitter; held stable from the tx_start_out pulse until the busy-wait ends.
tx_start_out  output  1  one-cycle start pulse to the UART transmitter.
tx_busy_in  input  1  UART transmitter busy.
frame_done  output  1  one-cycle pulse after the CRC low byte has completed transmission.
crc_out  output  16  CRC of the last completed frame; valid from the frame_done pulse until the next frame_done.
overflow_err  output  1  sticky flag: a frame hit MAX_LEN without in_last. Cleared only by reset.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=0, tx_data_out=0, tx_start_out=0, frame_done=0, crc_out=0, overflow_err=0, crc=CRC_INIT, byte count=0.
- CRC algorithm: CRC-16/CCITT-FALSE. MSB-first, no input/output reflection, no final XOR. Each accepted byte updates crc in the same cycle it is accepted. Check value: "123456789" gives 16'h29B1.
- FSM states: IDLE, SEND, GUARD, WAIT, CRC_HI, CRC_LO, DONE.
- IDLE: in_ready=1 when tx_busy_in=0. On a transfer:
  - latch the byte into tx_data_out, update crc, increment count, record last_f = in_last | (count+1==MAX_LEN).
  - go to SEND.
- SEND: tx_start_out=1 for exactly this cycle; go to GUARD.
- GUARD: one cycle in which tx_busy_in is ignored, covering the transmitter's one-cycle busy latency; go to WAIT.
- WAIT: hold until tx_busy_in=0, then:
  - if a data byte was sent and last_f=0, return to IDLE.
  - if a data byte was sent and last_f=1, go to CRC_HI.
  - after the CRC high byte, go to CRC_LO.
  - after the CRC low byte, go to DONE.
- CRC_HI / CRC_LO: load crc[15:8] / crc[7:0] into tx_data_out, then behave as SEND (start pulse, then GUARD, then WAIT).
- DONE: frame_done=1 for one cycle, crc_out=crc, crc reloads CRC_INIT, count=0; go to IDLE.
- in_ready is 0 in every state except IDLE. Throughput is at most one byte per UART character time plus 3 cycles.
- Overflow: when count reaches MAX_LEN with in_last=0, the frame is closed as if in_last were set, and overflow_err is set. Surplus input bytes wait in IDLE and start the next frame.
- in_last on the MAX_LEN-th byte is a normal close; overflow_err is not set.
- Zero-length frames are impossible; a frame always contains at least one byte.
- in_valid deasserted mid-frame: the block waits in IDLE indefinitely with crc and count preserved.
- reset asserted mid-frame: the partial frame is discarded, with no CRC bytes and no frame_done. The next frame starts from CRC_INIT.

Decomposition:
- Package crc16_pkg: CRC_POLY_DEF=16'h1021, CRC_INIT_DEF=16'hFFFF, the state enum encoding (3 bits), and the check value 16'h29B1 for benches.
- Sub-module crc16_byte_update: purely combinational. Takes crc_in[15:0] and data[7:0], produces crc_next[15:0] using an 8-iteration MSB-first shift/XOR loop.
- The framer FSM, counter and output registers stay in crc16_frame_tx.

Test Plan:
1. Send ASCII "123456789" (8'h31..8'h39) with in_last on 8'h39, using a UART model with busy for 20 cycles -> 11 tx_start_out pulses carrying 31..39 then 29, B1; one frame_done; crc_out=16'h29B1; overflow_err=0.
2. Same frame with in_valid toggled every other cycle and tx_busy_in held for 200 cycles per byte -> identical 11-byte output; no start pulse while tx_busy_in=1; in_ready=0 outside IDLE.
3. Two back-to-back "123456789" frames -> both yield trailing 29, B1, which proves the crc reseeds in DONE.
4. MAX_LEN=4, six bytes "123456" with no in_last -> first frame = 31..34 plus 2 CRC bytes matching the crc16_byte_update model; overflow_err=1 and stays high; bytes 35, 36 start the second frame.
5. Assert reset after the 5th byte's tx_start_out -> all outputs return to reset values immediately. A subsequent "123456789" frame gives crc_out=16'h29B1.
6. Single-byte frame 8'hAA with in_last -> 3 start pulses (AA, CRC hi, CRC lo) matching the model; frame_done asserted exactly 1 cycle after the final WAIT exit.
